// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
//   icache_state_t : refill FSM state (IDLE serves hits, FILL runs the line refill)
//   off_width/idx_width/tag_width : address field widths for a 32-bit byte address
//   ICACHE_NOP     : value driven on Instruction when no valid word is available
package icache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    localparam logic [31:0] ICACHE_NOP = 32'h0;

    function automatic int unsigned off_width(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int unsigned idx_width(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // Bits [1:0] are the byte offset inside a word and never reach the cache.
    function automatic int unsigned tag_width(input int unsigned lines,
                                              input int unsigned words_per_line);
        return 30 - $clog2(lines) - $clog2(words_per_line);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Storage for the instruction cache: valid bits, tag store and data store.
//   clk_i, rst_i      : clock, synchronous active-high reset (valid bits only)
//   clear_all_i       : invalidate every line at the next edge (wins over a commit)
//   rd_idx_i/rd_off_i : asynchronous read address
//   rd_valid_o/rd_tag_o/rd_data_o : read results for the addressed line/word
//   wr_en_i, wr_idx_i, wr_off_i, wr_data_i : single data write port
//   commit_i, commit_tag_i, commit_valid_i : write tag and valid bit of line wr_idx_i
module icache_array #(
    parameter int unsigned LINES          = 64,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned IDX_W          = 6,
    parameter int unsigned OFF_W          = 2,
    parameter int unsigned TAG_W          = 22
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_all_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [OFF_W-1:0] rd_off_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [OFF_W-1:0] wr_off_i,
    input  logic [31:0]      wr_data_i,
    input  logic             commit_i,
    input  logic [TAG_W-1:0] commit_tag_i,
    input  logic             commit_valid_i
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES*WORDS_PER_LINE];

    always_comb begin
        valid_d = valid_q;
        if (commit_i) begin
            valid_d[wr_idx_i] = commit_valid_i;
        end
        if (clear_all_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data contents are meaningless until the valid bit is set, so they are not reset.
    always_ff @(posedge clk_i) begin
        if (commit_i) begin
            tag_mem[wr_idx_i] <= commit_tag_i;
        end
        if (wr_en_i) begin
            data_mem[{wr_idx_i, wr_off_i}] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_mem[rd_idx_i];
    assign rd_data_o  = data_mem[{rd_idx_i, rd_off_i}];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache.
//   CLK, RST     : clock, synchronous active-high reset
//   PCForMem     : fetch byte address (bits [1:0] ignored)
//   Flush        : one-cycle pulse, invalidates every line
//   Instruction  : fetched word, valid when IF_Stall = 0 (0 otherwise)
//   IF_Stall     : instruction not available this cycle
//   MemAddr/MemReq/MemAck/MemRData : word-wide backing memory read handshake
// Hits are served combinationally; a miss refills the whole line, word 0 first.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned LINES          = 64,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PCForMem,
    input  logic        Flush,
    output logic [31:0] Instruction,
    output logic        IF_Stall,
    output logic [31:0] MemAddr,
    output logic        MemReq,
    input  logic        MemAck,
    input  logic [31:0] MemRData
);

    localparam int unsigned OFF_W  = off_width(WORDS_PER_LINE);
    localparam int unsigned IDX_W  = idx_width(LINES);
    localparam int unsigned TAG_W  = tag_width(LINES, WORDS_PER_LINE);
    localparam int unsigned LINE_W = TAG_W + IDX_W;

    logic [TAG_W-1:0] pc_tag;
    logic [IDX_W-1:0] pc_idx;
    logic [OFF_W-1:0] pc_off;
    logic             unused_pc_byte;

    assign pc_tag         = PCForMem[31 -: TAG_W];
    assign pc_idx         = PCForMem[2+OFF_W +: IDX_W];
    assign pc_off         = PCForMem[2 +: OFF_W];
    assign unused_pc_byte = ^PCForMem[1:0];

    icache_state_t     state_q, state_d;
    logic [LINE_W-1:0] fill_line_q, fill_line_d;  // {tag, idx} of the line being refilled
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic              flush_pend_q, flush_pend_d;

    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_idx;
    assign fill_tag = fill_line_q[LINE_W-1 -: TAG_W];
    assign fill_idx = fill_line_q[IDX_W-1:0];

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit;
    logic             ack_fill;
    logic             last_word;
    logic             wr_en;
    logic             commit;
    logic             commit_valid;

    assign hit       = rd_valid && (rd_tag == pc_tag) && (state_q == IDLE);
    assign ack_fill  = (state_q == FILL) && MemAck && !RST;
    assign last_word = (cnt_q == {OFF_W{1'b1}});
    assign wr_en     = ack_fill;
    assign commit    = ack_fill && last_word;
    // A flush arriving on the last ack must also keep this line invalid.
    assign commit_valid = !(flush_pend_q || Flush);

    icache_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IDX_W          (IDX_W),
        .OFF_W          (OFF_W),
        .TAG_W          (TAG_W)
    ) u_array (
        .clk_i          (CLK),
        .rst_i          (RST),
        .clear_all_i    (Flush),
        .rd_idx_i       (pc_idx),
        .rd_off_i       (pc_off),
        .rd_valid_o     (rd_valid),
        .rd_tag_o       (rd_tag),
        .rd_data_o      (rd_data),
        .wr_en_i        (wr_en),
        .wr_idx_i       (fill_idx),
        .wr_off_i       (cnt_q),
        .wr_data_i      (MemRData),
        .commit_i       (commit),
        .commit_tag_i   (fill_tag),
        .commit_valid_i (commit_valid)
    );

    always_comb begin
        state_d      = state_q;
        fill_line_d  = fill_line_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        unique case (state_q)
            IDLE: begin
                if (!hit && !RST) begin
                    fill_line_d = {pc_tag, pc_idx};
                    cnt_d       = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (Flush) begin
                    flush_pend_d = 1'b1;
                end
                if (MemAck) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_word) begin
                        flush_pend_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            fill_line_q  <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_line_q  <= fill_line_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // The address only moves at the edge after an ack, so it is stable while waiting.
    assign MemReq      = (state_q == FILL);
    assign MemAddr     = (state_q == FILL) ? {fill_line_q, cnt_q, 2'b00} : 32'h0;
    assign IF_Stall    = RST || !hit;
    assign Instruction = (hit && !RST) ? rd_data : ICACHE_NOP;

endmodule

// File: tb/tb_icache.sv
module tb_icache;

    localparam int LINES = 64;
    localparam int WPL   = 4;
    localparam int BOUND = 200;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] PCForMem = 32'h0;
    logic        Flush = 1'b0;
    logic [31:0] Instruction;
    logic        IF_Stall;
    logic [31:0] MemAddr;
    logic        MemReq;
    logic        MemAck;
    logic [31:0] MemRData;

    icache #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PCForMem    (PCForMem),
        .Flush       (Flush),
        .Instruction (Instruction),
        .IF_Stall    (IF_Stall),
        .MemAddr     (MemAddr),
        .MemReq      (MemReq),
        .MemAck      (MemAck),
        .MemRData    (MemRData)
    );

    always #5 CLK = ~CLK;

    // Backing memory: acks on the lat-th consecutive cycle of a request; data = A000_0000 | addr.
    int lat = 1;
    int wait_cnt = 0;
    logic spurious_ack = 1'b0;
    assign MemAck   = (MemReq && (wait_cnt == lat - 1)) || spurious_ack;
    assign MemRData = 32'hA000_0000 | MemAddr;
    always @(posedge CLK) begin
        if (!MemReq || MemAck) wait_cnt <= 0;
        else                   wait_cnt <= wait_cnt + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: which tag is resident in each line.
    bit          mvalid [LINES];
    logic [31:0] mtag   [LINES];

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 4) % LINES);
    endfunction

    function automatic logic [31:0] m_tag(input logic [31:0] pc);
        return pc >> 10;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return mvalid[m_idx(pc)] && (mtag[m_idx(pc)] == m_tag(pc));
    endfunction

    task automatic m_fill(input logic [31:0] pc);
        mvalid[m_idx(pc)] = 1'b1;
        mtag[m_idx(pc)]   = m_tag(pc);
    endtask

    task automatic m_clear();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endtask

    logic [31:0] ack_addrs[$];
    logic [31:0] req_addrs[$];
    bit          flush_first = 1'b0;

    // Presents pc until the cache delivers; reports stall cycles and observed traffic.
    // Entered and left 1 time unit after a rising edge.
    task automatic do_fetch(input logic [31:0] pc, output int stall, output logic [31:0] instr);
        ack_addrs.delete();
        req_addrs.delete();
        PCForMem = pc;
        Flush    = flush_first;
        stall    = 0;
        instr    = 32'hDEAD_BEEF;
        while (stall < BOUND) begin
            #4;
            if (!IF_Stall) begin
                instr = Instruction;
                break;
            end
            stall++;
            if (MemReq) req_addrs.push_back(MemAddr);
            if (MemReq && MemAck) ack_addrs.push_back(MemAddr);
            @(posedge CLK); #1;
            Flush = 1'b0;
        end
        @(posedge CLK); #1;
        Flush = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        PCForMem = 32'h0;
        repeat (3) begin @(posedge CLK); #1; end
        #4;
        n_cmp++; if (IF_Stall !== 1'b1) begin n_err++; $display("FAIL reset_stall got=%b want=1", IF_Stall); end
        n_cmp++; if (Instruction !== 32'h0) begin n_err++; $display("FAIL reset_instr got=%h want=0", Instruction); end
        n_cmp++; if (MemReq !== 1'b0) begin n_err++; $display("FAIL reset_memreq got=%b want=0", MemReq); end
        n_cmp++; if (MemAddr !== 32'h0) begin n_err++; $display("FAIL reset_memaddr got=%h want=0", MemAddr); end
        @(posedge CLK); #1;
        m_clear();
        RST = 1'b0;
    endtask

    task automatic test_cold_miss();
        int st;
        logic [31:0] ins;
        do_fetch(32'h0, st, ins);
        n_cmp++; if (st !== 5) begin n_err++; $display("FAIL cold_stall got=%0d want=5", st); end
        n_cmp++; if (ack_addrs.size() !== 4) begin n_err++; $display("FAIL cold_nacks got=%0d want=4", ack_addrs.size()); end
        for (int i = 0; i < ack_addrs.size() && i < 4; i++) begin
            n_cmp++;
            if (ack_addrs[i] !== 32'(4 * i)) begin
                n_err++; $display("FAIL cold_addr%0d got=%h want=%h", i, ack_addrs[i], 32'(4 * i));
            end
        end
        n_cmp++; if (ins !== 32'hA000_0000) begin n_err++; $display("FAIL cold_instr got=%h want=a0000000", ins); end
        m_fill(32'h0);
    endtask

    task automatic test_line_hits();
        int st;
        logic [31:0] ins;
        for (int i = 1; i < 4; i++) begin
            do_fetch(32'(4 * i), st, ins);
            n_cmp++; if (st !== 0) begin n_err++; $display("FAIL hit%0d_stall got=%0d want=0", i, st); end
            n_cmp++; if (req_addrs.size() !== 0) begin n_err++; $display("FAIL hit%0d_req got=%0d want=0", i, req_addrs.size()); end
            n_cmp++;
            if (ins !== (32'hA000_0000 | 32'(4 * i))) begin
                n_err++; $display("FAIL hit%0d_instr got=%h want=%h", i, ins, 32'hA000_0000 | 32'(4 * i));
            end
        end
    endtask

    task automatic test_spurious_ack();
        int st;
        logic [31:0] ins;
        spurious_ack = 1'b1;
        do_fetch(32'h8, st, ins);
        spurious_ack = 1'b0;
        do_fetch(32'hC, st, ins);
        n_cmp++; if (st !== 0) begin n_err++; $display("FAIL spurious_stall got=%0d want=0", st); end
        n_cmp++; if (ins !== 32'hA000_000C) begin n_err++; $display("FAIL spurious_instr got=%h want=a000000c", ins); end
    endtask

    task automatic test_conflict();
        int st;
        logic [31:0] ins;
        do_fetch(32'h400, st, ins);
        n_cmp++; if (st !== 5) begin n_err++; $display("FAIL conflict_stall got=%0d want=5", st); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= ack_addrs.size() || ack_addrs[i] !== 32'h400 + 32'(4 * i)) begin
                n_err++; $display("FAIL conflict_addr%0d got=%h want=%h", i,
                                  (i < ack_addrs.size()) ? ack_addrs[i] : 32'hX, 32'h400 + 32'(4 * i));
            end
        end
        n_cmp++; if (ins !== 32'hA000_0400) begin n_err++; $display("FAIL conflict_instr got=%h want=a0000400", ins); end
        m_fill(32'h400);
        do_fetch(32'h0, st, ins);
        n_cmp++; if (st !== 5) begin n_err++; $display("FAIL conflict_back_stall got=%0d want=5", st); end
        n_cmp++; if (ins !== 32'hA000_0000) begin n_err++; $display("FAIL conflict_back_instr got=%h want=a0000000", ins); end
        m_fill(32'h0);
    endtask

    task automatic test_slow_memory();
        int st;
        logic [31:0] ins;
        lat = 3;
        do_fetch(32'h1238, st, ins);
        lat = 1;
        n_cmp++; if (st !== 13) begin n_err++; $display("FAIL slow_stall got=%0d want=13", st); end
        n_cmp++; if (req_addrs.size() !== 12) begin n_err++; $display("FAIL slow_nreq got=%0d want=12", req_addrs.size()); end
        for (int i = 0; i < req_addrs.size() && i < 12; i++) begin
            n_cmp++;
            if (req_addrs[i] !== 32'h1230 + 32'(4 * (i / 3))) begin
                n_err++; $display("FAIL slow_addr%0d got=%h want=%h", i, req_addrs[i], 32'h1230 + 32'(4 * (i / 3)));
            end
        end
        n_cmp++; if (ins !== 32'hA000_1238) begin n_err++; $display("FAIL slow_instr got=%h want=a0001238", ins); end
        m_fill(32'h1238);
    endtask

    task automatic test_flush_mid_fill();
        int st, acks, cyc;
        bit flushed;
        logic [31:0] ins;
        do_fetch(32'h0, st, ins);
        m_fill(32'h0);
        PCForMem = 32'h20;
        flushed = 1'b0;
        acks = 0;
        cyc = 0;
        while (acks < 4 && cyc < BOUND) begin
            if (!flushed && MemReq && MemAddr == 32'h24) begin
                Flush = 1'b1;
                flushed = 1'b1;
            end
            #4;
            if (MemReq && MemAck) acks++;
            @(posedge CLK); #1;
            Flush = 1'b0;
            cyc++;
        end
        n_cmp++; if (acks !== 4 || !flushed) begin n_err++; $display("FAIL flush_fill_acks got=%0d want=4 flushed=%b", acks, flushed); end
        #4;
        n_cmp++; if (IF_Stall !== 1'b1) begin n_err++; $display("FAIL flush_after_stall got=%b want=1", IF_Stall); end
        @(posedge CLK); #1;
        n_cmp++;
        if (MemReq !== 1'b1 || MemAddr !== 32'h20) begin
            n_err++; $display("FAIL flush_refill_start got req=%b addr=%h want req=1 addr=00000020", MemReq, MemAddr);
        end
        m_clear();
        do_fetch(32'h20, st, ins);
        n_cmp++; if (ins !== 32'hA000_0020) begin n_err++; $display("FAIL flush_refill_instr got=%h want=a0000020", ins); end
        m_fill(32'h20);
        do_fetch(32'h0, st, ins);
        n_cmp++; if (st !== 5) begin n_err++; $display("FAIL flush_line0_stall got=%0d want=5", st); end
        m_fill(32'h0);
    endtask

    task automatic test_reset_mid_fill();
        int st, acks, cyc;
        logic [31:0] ins;
        PCForMem = 32'h40;
        acks = 0;
        cyc = 0;
        while (acks < 2 && cyc < BOUND) begin
            #4;
            if (MemReq && MemAck) acks++;
            @(posedge CLK); #1;
            cyc++;
        end
        n_cmp++; if (acks !== 2) begin n_err++; $display("FAIL rstfill_acks got=%0d want=2", acks); end
        RST = 1'b1;
        #4;
        n_cmp++; if (IF_Stall !== 1'b1) begin n_err++; $display("FAIL rstfill_stall got=%b want=1", IF_Stall); end
        @(posedge CLK); #1;
        n_cmp++; if (MemReq !== 1'b0) begin n_err++; $display("FAIL rstfill_memreq got=%b want=0", MemReq); end
        @(posedge CLK); #1;
        RST = 1'b0;
        m_clear();
        do_fetch(32'h0, st, ins);
        n_cmp++; if (st !== 5) begin n_err++; $display("FAIL rstfill_refill_stall got=%0d want=5", st); end
        n_cmp++;
        if (ack_addrs.size() < 1 || ack_addrs[0] !== 32'h0) begin
            n_err++; $display("FAIL rstfill_first_addr got=%h want=0", (ack_addrs.size() > 0) ? ack_addrs[0] : 32'hX);
        end
        n_cmp++; if (ins !== 32'hA000_0000) begin n_err++; $display("FAIL rstfill_instr got=%h want=a0000000", ins); end
        m_fill(32'h0);
    endtask

    task automatic test_random();
        int st, exp_st;
        bit h, fl;
        logic [31:0] pc, ins, base;
        for (int n = 0; n < 60; n++) begin
            pc  = 32'($urandom_range(0, 2)) * 32'h400 + 32'($urandom_range(0, 7)) * 32'h10
                + 32'($urandom_range(0, 3)) * 32'h4 + 32'($urandom_range(0, 3));
            lat = $urandom_range(1, 3);
            fl  = ($urandom_range(0, 9) == 0);
            h   = m_hit(pc);
            exp_st = h ? 0 : 1 + WPL * lat;
            flush_first = fl;
            do_fetch(pc, st, ins);
            flush_first = 1'b0;
            n_cmp++;
            if (st !== exp_st) begin
                n_err++; $display("FAIL rand%0d_stall pc=%h got=%0d want=%0d", n, pc, st, exp_st);
            end
            n_cmp++;
            if (ins !== (32'hA000_0000 | (pc & ~32'h3))) begin
                n_err++; $display("FAIL rand%0d_instr pc=%h got=%h want=%h", n, pc, ins, 32'hA000_0000 | (pc & ~32'h3));
            end
            if (!h) begin
                base = pc & ~32'hF;
                n_cmp++;
                if (ack_addrs.size() !== WPL || ack_addrs[0] !== base || ack_addrs[WPL-1] !== base + 32'hC) begin
                    n_err++; $display("FAIL rand%0d_fill pc=%h nacks=%0d want=%0d from %h", n, pc,
                                      ack_addrs.size(), WPL, base);
                end
            end
            if (fl) m_clear();
            if (!h) m_fill(pc);
        end
        lat = 1;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_line_hits();
        test_spurious_ack();
        test_conflict();
        test_slow_memory();
        test_flush_mid_fill();
        test_reset_mid_fill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
